pipeline_ctrl: RTL and testbench

Parametrised pipeline control block for the in-order processor family: tracks per-stage valid bits, detects load-use hazards, and freezes the pipe while data memory is not ready. Resolves branch flushes and generates per-stage enables, bubbles and PC stall. Keeps saturating performance counters.
Stage 0 = IF, stage 1 = ID, stage 2 = EX, stage NUM_STAGES-1 = WB. Datapath pipeline registers load only when the matching stage_en bit is high.

---
 rtl/pipeline_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control: per-stage valid tracking, load-use stall, memory-wait freeze,
// branch flush, per-stage enables and saturating performance counters.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   if_valid_in           fetched instruction present at IF
//   id_*                  register usage / class of the instruction in ID
//   branch_taken          branch in ID resolved taken
//   mem_ready             data memory completes its access this cycle
//   stage_valid[i]        valid bit of stage i (0=IF, 1=ID, 2=EX, ...)
//   stage_en[i]           load enable of the pipeline register feeding stage i
//   pc_stall              hold the PC
//   flush_if              kill the IF instruction and redirect the PC
//   stall_cnt, flush_cnt, memwait_cnt   saturating event counters
module pipeline_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int MEM_STAGE  = 2,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid_in,
    input  logic [REG_ADDR_W-1:0] id_rA_addr,
    input  logic [REG_ADDR_W-1:0] id_rB_addr,
    input  logic                  id_uses_rA,
    input  logic                  id_uses_rB,
    input  logic [REG_ADDR_W-1:0] id_rD_addr,
    input  logic                  id_writes_rd,
    input  logic                  id_is_load,
    input  logic                  id_is_store,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  pc_stall,
    output logic                  flush_if,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      memwait_cnt
);

    localparam int N = NUM_STAGES;

    logic [N-1:0]          valid_q, valid_d;

    // Shadow info is only ever consulted up to the memory stage (hazard
    // detection and the memory freeze), so nothing is kept beyond it.
    logic [REG_ADDR_W-1:0] rd_q [2:MEM_STAGE];
    logic [REG_ADDR_W-1:0] rd_d [2:MEM_STAGE];
    logic [MEM_STAGE:2]    wr_q, wr_d;
    logic [MEM_STAGE:2]    ld_q, ld_d;
    logic [MEM_STAGE:2]    ma_q, ma_d;

    logic [CNT_W-1:0]      stall_q, stall_d;
    logic [CNT_W-1:0]      flush_q, flush_d;
    logic [CNT_W-1:0]      memwait_q, memwait_d;

    logic                  freeze_mem;
    logic                  hazard;
    logic                  lu_stall;
    logic                  flush;
    logic [N-1:0]          hold;
    logic [N-1:0]          bubble;

    always_comb begin
        freeze_mem = valid_q[MEM_STAGE] & ma_q[MEM_STAGE] & ~mem_ready;
        hazard     = 1'b0;
        for (int s = 2; s <= MEM_STAGE; s++) begin
            if (valid_q[s] && ld_q[s] && wr_q[s]) begin
                if ((id_uses_rA && rd_q[s] == id_rA_addr) ||
                    (id_uses_rB && rd_q[s] == id_rB_addr)) begin
                    hazard = 1'b1;
                end
            end
        end
        lu_stall = valid_q[1] & hazard & ~freeze_mem;
        flush    = valid_q[1] & branch_taken & ~lu_stall & ~freeze_mem;
        for (int i = 0; i < N; i++) begin
            hold[i] = ((i <= MEM_STAGE) && freeze_mem) ||
                      ((i <= 1) && lu_stall);
        end
        // A moving stage directly behind a held one receives a bubble.
        bubble = {hold[N-2:0] & ~hold[N-1:1], 1'b0};
    end

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ld_d    = ld_q;
        ma_d    = ma_q;

        if (!hold[0]) valid_d[0] = if_valid_in;

        if (bubble[1])     valid_d[1] = 1'b0;
        else if (!hold[1]) valid_d[1] = valid_q[0] & ~flush;

        for (int i = 2; i < N; i++) begin
            if (bubble[i])     valid_d[i] = 1'b0;
            else if (!hold[i]) valid_d[i] = valid_q[i-1];
        end

        if (bubble[2]) begin
            wr_d[2] = 1'b0;
            ld_d[2] = 1'b0;
            ma_d[2] = 1'b0;
        end else if (!hold[2]) begin
            rd_d[2] = id_rD_addr;
            wr_d[2] = valid_q[1] & id_writes_rd;
            ld_d[2] = valid_q[1] & id_is_load;
            ma_d[2] = valid_q[1] & (id_is_load | id_is_store);
        end

        for (int i = 3; i <= MEM_STAGE; i++) begin
            if (bubble[i]) begin
                wr_d[i] = 1'b0;
                ld_d[i] = 1'b0;
                ma_d[i] = 1'b0;
            end else if (!hold[i]) begin
                rd_d[i] = rd_q[i-1];
                wr_d[i] = wr_q[i-1];
                ld_d[i] = ld_q[i-1];
                ma_d[i] = ma_q[i-1];
            end
        end

        stall_d   = (lu_stall && stall_q != '1) ?
                    stall_q + CNT_W'(1) : stall_q;
        flush_d   = (flush && flush_q != '1) ?
                    flush_q + CNT_W'(1) : flush_q;
        memwait_d = (freeze_mem && memwait_q != '1) ?
                    memwait_q + CNT_W'(1) : memwait_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            wr_q      <= '0;
            ld_q      <= '0;
            ma_q      <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
            for (int s = 2; s <= MEM_STAGE; s++) begin
                rd_q[s] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ld_q      <= ld_d;
            ma_q      <= ma_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            memwait_q <= memwait_d;
        end
    end

    assign stage_valid = valid_q;
    assign stage_en    = ~hold;
    assign pc_stall    = hold[0];
    assign flush_if    = flush;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign memwait_cnt = memwait_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: slot-level pipe model checked every cycle on two
// instances (16-bit and 2-bit counters) plus hand-computed directed checks.
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic       if_valid_in;
    logic [4:0] id_rA_addr, id_rB_addr, id_rD_addr;
    logic       id_uses_rA, id_uses_rB, id_writes_rd;
    logic       id_is_load, id_is_store, branch_taken, mem_ready;

    logic [3:0]  sv1, en1, sv2, en2;
    logic        ps1, fl1, ps2, fl2;
    logic [15:0] sc1, fc1, mc1;
    logic [1:0]  sc2, fc2, mc2;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl #(.NUM_STAGES(4), .MEM_STAGE(2), .REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .if_valid_in(if_valid_in),
        .id_rA_addr(id_rA_addr), .id_rB_addr(id_rB_addr),
        .id_uses_rA(id_uses_rA), .id_uses_rB(id_uses_rB),
        .id_rD_addr(id_rD_addr), .id_writes_rd(id_writes_rd),
        .id_is_load(id_is_load), .id_is_store(id_is_store),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stage_valid(sv1), .stage_en(en1), .pc_stall(ps1), .flush_if(fl1),
        .stall_cnt(sc1), .flush_cnt(fc1), .memwait_cnt(mc1)
    );

    pipeline_ctrl #(.NUM_STAGES(4), .MEM_STAGE(2), .REG_ADDR_W(5), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .if_valid_in(if_valid_in),
        .id_rA_addr(id_rA_addr), .id_rB_addr(id_rB_addr),
        .id_uses_rA(id_uses_rA), .id_uses_rB(id_uses_rB),
        .id_rD_addr(id_rD_addr), .id_writes_rd(id_writes_rd),
        .id_is_load(id_is_load), .id_is_store(id_is_store),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stage_valid(sv2), .stage_en(en2), .pc_stall(ps2), .flush_if(fl2),
        .stall_cnt(sc2), .flush_cnt(fc2), .memwait_cnt(mc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model: one slot per stage ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       ma;
    } slot_t;

    slot_t m [4];
    slot_t nx [4];
    int    n_stall = 0, n_flush = 0, n_mw = 0;
    int    k;
    logic  e_freeze, e_haz, e_lu, e_fl;
    logic [3:0] e_valid, e_en;

    initial for (int i = 0; i < 4; i++) m[i] = '0;

    always_comb begin
        e_freeze = m[2].v && m[2].ma && !mem_ready;
        e_haz    = m[2].v && m[2].ld && m[2].wr &&
                   ((id_uses_rA && m[2].rd == id_rA_addr) ||
                    (id_uses_rB && m[2].rd == id_rB_addr));
        e_lu     = m[1].v && e_haz && !e_freeze;
        e_fl     = m[1].v && branch_taken && !e_lu && !e_freeze;
        // everything up to stage k stands still, stage k+1 gets a bubble
        k        = e_freeze ? 2 : (e_lu ? 1 : -1);
        for (int i = 0; i < 4; i++) begin
            e_valid[i] = m[i].v;
            e_en[i]    = (i > k);
        end
        for (int i = 0; i < 4; i++) nx[i] = m[i];
        for (int i = 0; i < 4; i++) begin
            if (i <= k) nx[i] = m[i];
            else if (i == k + 1 && i > 0) nx[i] = '0;
            else if (i == 0) nx[0] = '{v: if_valid_in, default: '0};
            else if (i == 1) nx[1] = '{v: m[0].v && !e_fl, default: '0};
            else if (i == 2) nx[2] = '{v: m[1].v, rd: id_rD_addr,
                                       wr: m[1].v && id_writes_rd,
                                       ld: m[1].v && id_is_load,
                                       ma: m[1].v && (id_is_load || id_is_store)};
            else nx[i] = m[i-1];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m[i] <= '0;
            n_stall <= 0;
            n_flush <= 0;
            n_mw    <= 0;
        end else begin
            for (int i = 0; i < 4; i++) m[i] <= nx[i];
            n_stall <= n_stall + int'(e_lu);
            n_flush <= n_flush + int'(e_fl);
            n_mw    <= n_mw + int'(e_freeze);
        end
    end

    function automatic logic [31:0] sat(int n, int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_valid",   32'(sv1), 32'(e_valid));
        chk("m_en",      32'(en1), 32'(e_en));
        chk("m_pcstall", 32'(ps1), 32'(k >= 0));
        chk("m_flush",   32'(fl1), 32'(e_fl));
        chk("m_stall",   32'(sc1), sat(n_stall, 16));
        chk("m_flcnt",   32'(fc1), sat(n_flush, 16));
        chk("m_mwcnt",   32'(mc1), sat(n_mw, 16));
        chk("m2_valid",  32'(sv2), 32'(e_valid));
        chk("m2_en",     32'(en2), 32'(e_en));
        chk("m2_stall",  32'(sc2), sat(n_stall, 2));
        chk("m2_flcnt",  32'(fc2), sat(n_flush, 2));
        chk("m2_mwcnt",  32'(mc2), sat(n_mw, 2));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_rA_addr = 0; id_rB_addr = 0; id_rD_addr = 0;
        id_uses_rA = 0; id_uses_rB = 0; id_writes_rd = 0;
        id_is_load = 0; id_is_store = 0; branch_taken = 0;
    endtask

    task automatic fill();
        clear_id();
        if_valid_in = 1;
        mem_ready   = 1;
        repeat (4) tick();
    endtask

    task automatic load_then_use(input logic [4:0] r);
        id_is_load = 1; id_writes_rd = 1; id_rD_addr = r;
        tick();
        clear_id();
        id_uses_rA = 1; id_rA_addr = r;
        tick();
        tick();
        clear_id();
    endtask

    initial begin
        reset = 1;
        if_valid_in = 0;
        mem_ready = 1;
        clear_id();
        tick();
        tick();
        chk("rst_valid", 32'(sv1), 32'h0);
        chk("rst_en",    32'(en1), 32'hF);
        chk("rst_pc",    32'(ps1), 32'h0);
        chk("rst_cnt",   32'(sc1 | fc1 | mc1), 32'h0);

        reset = 0;
        if_valid_in = 1;
        tick(); chk("walk1", 32'(sv1), 32'b0001);
        tick(); chk("walk2", 32'(sv1), 32'b0011);
        tick(); chk("walk3", 32'(sv1), 32'b0111);
        tick(); chk("walk4", 32'(sv1), 32'b1111);
        chk("walk_en", 32'(en1), 32'hF);

        // load r3 then consumer of r3
        id_is_load = 1; id_writes_rd = 1; id_rD_addr = 3;
        tick();
        clear_id();
        id_uses_rA = 1; id_rA_addr = 3; id_writes_rd = 1; id_rD_addr = 4;
        #1;
        chk("lu_pc", 32'(ps1), 32'h1);
        chk("lu_en", 32'(en1), 32'b1100);
        tick();
        chk("lu_bub",   32'(sv1), 32'b1011);
        chk("lu_cnt",   32'(sc1), 32'd1);
        chk("lu_pc2",   32'(ps1), 32'h0);
        tick();
        chk("lu_after", 32'(sv1), 32'b0111);

        // store frozen on mem_ready for 3 cycles
        clear_id();
        id_is_store = 1;
        tick();
        chk("st_in", 32'(sv1), 32'b1111);
        clear_id();
        mem_ready = 0;
        #1;
        chk("mw_en", 32'(en1), 32'b1000);
        chk("mw_pc", 32'(ps1), 32'h1);
        repeat (3) tick();
        chk("mw_valid", 32'(sv1), 32'b0111);
        chk("mw_cnt",   32'(mc1), 32'd3);
        mem_ready = 1;
        #1;
        chk("mw_rel_en", 32'(en1), 32'hF);
        tick();
        chk("mw_rel_v", 32'(sv1), 32'b1111);

        // taken branch
        branch_taken = 1;
        #1;
        chk("br_flush", 32'(fl1), 32'h1);
        tick();
        branch_taken = 0;
        chk("br_valid", 32'(sv1), 32'b1101);
        chk("br_cnt",   32'(fc1), 32'd1);

        fill();
        chk("fill1", 32'(sv1), 32'hF);

        // branch together with a load-use hazard
        id_is_load = 1; id_writes_rd = 1; id_rD_addr = 7;
        tick();
        clear_id();
        id_uses_rB = 1; id_rB_addr = 7; branch_taken = 1;
        #1;
        chk("bh_flush0", 32'(fl1), 32'h0);
        chk("bh_pc",     32'(ps1), 32'h1);
        tick();
        chk("bh_stall",  32'(sc1), 32'd2);
        chk("bh_flush1", 32'(fl1), 32'h1);
        tick();
        chk("bh_fcnt",   32'(fc1), 32'd2);
        clear_id();

        // drive the 2-bit counters to saturation
        fill();
        branch_taken = 1;
        tick();
        branch_taken = 0;
        fill();
        load_then_use(5'd9);
        fill();
        chk("sat_st2", 32'(sc2), 32'd3);
        chk("sat_fl2", 32'(fc2), 32'd3);
        chk("sat_mw2", 32'(mc2), 32'd3);
        chk("sat_st1", 32'(sc1), 32'd3);
        branch_taken = 1;
        tick();
        branch_taken = 0;
        chk("sat_fl1", 32'(fc1), 32'd4);
        chk("sat_hold", 32'(fc2), 32'd3);
        fill();
        id_is_store = 1;
        tick();
        clear_id();
        mem_ready = 0;
        tick();
        tick();
        chk("mw5",    32'(mc1), 32'd5);
        chk("mw_sat", 32'(mc2), 32'd3);

        // reset in the middle of a freeze
        reset = 1;
        tick();
        chk("mr_valid", 32'(sv1 | sv2), 32'h0);
        chk("mr_cnt1",  32'(sc1 | fc1 | mc1), 32'h0);
        chk("mr_cnt2",  32'(sc2 | fc2 | mc2), 32'h0);
        chk("mr_en",    32'(en1), 32'hF);
        reset = 0;
        fill();
        chk("final_v", 32'(sv1), 32'hF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
